// File: rtl/dff_bist_pkg.sv
// -----------------------------------------------------------------------------
// dff_bist_pkg
// Shared definitions for the D-flop BIST controller:
//   bist_state_e  - controller FSM states
//   ERR_W         - width of the saturating mismatch counter
//   FAIL_NONE     - all-ones "no failure seen" marker (slice to CNT_W)
//   err_sat_inc() - saturating increment of the mismatch counter
//   run_en()      - enable pattern used during the RUN phase
// -----------------------------------------------------------------------------
package dff_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bist_state_e;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_ZERO = 8'h00;
  localparam logic [ERR_W-1:0] ERR_MAX  = 8'hFF;
  localparam logic [31:0]      FAIL_NONE = 32'hFFFF_FFFF;

  // Mismatch counter increment that sticks at its maximum.
  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] cnt);
    logic [ERR_W-1:0] res;
    if (cnt == ERR_MAX) begin
      res = cnt;
    end else begin
      res = cnt + 8'd1;
    end
    return res;
  endfunction

  // Enable is dropped for run counts 8..11 of every 16 so the flop under
  // test is forced through hold cycles while data keeps toggling.
  function automatic logic run_en(input logic [3:0] run_lo);
    return (run_lo[3:2] != 2'b10);
  endfunction

endpackage

// File: rtl/dff_bist_ctrl_if.sv
// -----------------------------------------------------------------------------
// dff_bist_ctrl_if
// Bundles the BIST control/status signals and the flop-under-test stimulus
// and response.
//   start            host -> ctrl  one-cycle test start pulse
//   dut_rst/en/d     ctrl -> FUT   registered stimulus
//   dut_q            FUT  -> ctrl  flop under test output
//   busy/done/pass   ctrl -> host  status
//   err_count        ctrl -> host  saturating mismatch count
//   first_fail_cycle ctrl -> host  cycle of first mismatch, all-ones if none
// Modports: master = host/FUT side, slave = BIST controller.
// -----------------------------------------------------------------------------
interface dff_bist_ctrl_if #(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
);
  import dff_bist_pkg::*;

  logic                start;
  logic                dut_rst;
  logic                dut_en;
  logic [DATA_W-1:0]   dut_d;
  logic [DATA_W-1:0]   dut_q;
  logic                busy;
  logic                done;
  logic                pass;
  logic [ERR_W-1:0]    err_count;
  logic [CNT_W-1:0]    first_fail_cycle;

  modport master (
    output start, dut_q,
    input  dut_rst, dut_en, dut_d, busy, done, pass, err_count, first_fail_cycle
  );

  modport slave (
    input  start, dut_q,
    output dut_rst, dut_en, dut_d, busy, done, pass, err_count, first_fail_cycle
  );

endinterface

// File: rtl/dff_bist_model.sv
// -----------------------------------------------------------------------------
// dff_bist_model
// Shadow reference of a D flop with enable and active-high sync reset, plus
// an equality comparator against the real flop output.
//   clk_i       clock, rising edge
//   rst_ni      asynchronous reset, active-low (clears the shadow)
//   dut_rst_i   reset applied to the flop under test
//   dut_en_i    enable applied to the flop under test
//   dut_d_i     data applied to the flop under test
//   dut_q_i     flop under test output
//   cmp_en_i    qualify the comparison
//   mismatch_o  dut_q_i differs from the shadow while cmp_en_i is high
// -----------------------------------------------------------------------------
module dff_bist_model #(
  parameter int DATA_W = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dut_rst_i,
  input  logic              dut_en_i,
  input  logic [DATA_W-1:0] dut_d_i,
  input  logic [DATA_W-1:0] dut_q_i,
  input  logic              cmp_en_i,
  output logic              mismatch_o
);

  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0] shadow_d;

  // Next value of the ideal flop, evaluated on the same inputs as the FUT.
  always_comb begin
    shadow_d = shadow_q;
    if (dut_rst_i) begin
      shadow_d = DATA_ZERO;
    end else if (dut_en_i) begin
      shadow_d = dut_d_i;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Shadow flop register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= DATA_ZERO;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // Both sides are registered, so they are compared in the same cycle.
  assign mismatch_o = cmp_en_i && (dut_q_i != shadow_q);

endmodule

// File: rtl/dff_bist_ctrl.sv
// -----------------------------------------------------------------------------
// dff_bist_ctrl
// BIST controller for a D flop with enable and active-high reset. Drives
// reset/enable/data stimulus into the flop under test, tracks a shadow model
// and reports pass/fail, a saturating error count and the first failing cycle.
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-low
//   bus   dff_bist_ctrl_if.slave (start, dut_*, busy, done, pass, err_count,
//         first_fail_cycle)
// Build option: define DFF_BIST_STOP_ON_FAIL_EN to end the test on the first
// mismatch; otherwise the full RUN and DRAIN always execute.
// CNT_W must be at least 4 (the enable pattern looks at run count bits 3:2).
// -----------------------------------------------------------------------------
module dff_bist_ctrl
  import dff_bist_pkg::*;
#(
  parameter int DATA_W        = 1,
  parameter int RST_CYCLES    = 5,
  parameter int TOGGLE_PERIOD = 3,
  parameter int TEST_LEN      = 22,
  parameter int CNT_W         = 8
) (
  input  logic          clk,
  input  logic          rst,
  dff_bist_ctrl_if.slave bus
);

`ifdef DFF_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TEST_LEN - 1);
  localparam logic [CNT_W-1:0]  TOG_LAST  = CNT_W'(TOGGLE_PERIOD - 1);
  localparam logic [CNT_W-1:0]  FAIL_NONE_W = FAIL_NONE[CNT_W-1:0];
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  bist_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // cycles within RESET, run_cnt within RUN
  logic [CNT_W-1:0]  cyc_q, cyc_d;      // global cycle index, 0 at first RESET cycle
  logic [CNT_W-1:0]  tog_q, tog_d;      // cycles since last data inversion
  logic [CNT_W-1:0]  ff_q, ff_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              dut_rst_q, dut_rst_d;
  logic              dut_en_q, dut_en_d;
  logic [DATA_W-1:0] dut_d_q, dut_d_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              accept_s;
  logic              cmp_en_s;
  logic              mismatch_s;
  logic              stop_s;

  assign cnt_nxt_s = cnt_q + CNT_ONE;
  assign stop_s    = STOP_ON_FAIL && mismatch_s;

  // Start is honoured only from IDLE or DONE; pulses while busy are dropped.
  always_comb begin
    accept_s = 1'b0;
    if ((state_q == IDLE) || (state_q == DONE)) begin
      accept_s = bus.start;
    end else begin
      accept_s = 1'b0;
    end
  end

  // The first RESET cycle still shows the flop's pre-test value, so skip it.
  always_comb begin
    cmp_en_s = 1'b0;
    case (state_q)
      RESET:     cmp_en_s = (cyc_q != CNT_ZERO);
      RUN:       cmp_en_s = 1'b1;
      DRAIN:     cmp_en_s = 1'b1;
      default:   cmp_en_s = 1'b0;
    endcase
  end

  dff_bist_model #(
    .DATA_W (DATA_W)
  ) u_model (
    .clk_i      (clk),
    .rst_ni     (rst),
    .dut_rst_i  (dut_rst_q),
    .dut_en_i   (dut_en_q),
    .dut_d_i    (dut_d_q),
    .dut_q_i    (bus.dut_q),
    .cmp_en_i   (cmp_en_s),
    .mismatch_o (mismatch_s)
  );

  // Next-state, stimulus and result logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    tog_d     = tog_q;
    dut_rst_d = dut_rst_q;
    dut_en_d  = dut_en_q;
    dut_d_d   = dut_d_q;
    err_d     = err_q;
    ff_d      = ff_q;

    // Result bookkeeping first so an accepted start below overrides it.
    if (mismatch_s) begin
      err_d = err_sat_inc(err_q);
      if (err_q == ERR_ZERO) begin
        ff_d = cyc_q;
      end else begin
        ff_d = ff_q;
      end
    end else begin
      err_d = err_q;
      ff_d  = ff_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d   = RESET;
          cnt_d     = CNT_ZERO;
          cyc_d     = CNT_ZERO;
          tog_d     = CNT_ZERO;
          dut_rst_d = 1'b1;
          dut_en_d  = 1'b0;
          dut_d_d   = DATA_ZERO;
          err_d     = ERR_ZERO;
          ff_d      = FAIL_NONE_W;
        end else begin
          state_d = state_q;
        end
      end
      RESET: begin
        if (stop_s) begin
          state_d  = DONE;
          dut_en_d = 1'b0;
        end else begin
          cyc_d = cyc_q + CNT_ONE;
          if (cnt_q == RST_LAST) begin
            state_d   = RUN;
            cnt_d     = CNT_ZERO;
            tog_d     = CNT_ZERO;
            dut_rst_d = 1'b0;
            dut_en_d  = run_en(4'b0000);
            dut_d_d   = DATA_ZERO;
          end else begin
            cnt_d = cnt_nxt_s;
          end
        end
      end
      RUN: begin
        if (stop_s) begin
          state_d  = DONE;
          dut_en_d = 1'b0;
        end else begin
          cyc_d = cyc_q + CNT_ONE;
          if (cnt_q == RUN_LAST) begin
            state_d  = DRAIN;
            dut_en_d = 1'b0;
          end else begin
            cnt_d    = cnt_nxt_s;
            dut_en_d = run_en(cnt_nxt_s[3:0]);
            if (tog_q == TOG_LAST) begin
              tog_d   = CNT_ZERO;
              dut_d_d = ~dut_d_q;
            end else begin
              tog_d = tog_q + CNT_ONE;
            end
          end
        end
      end
      DRAIN: begin
        state_d  = DONE;
        dut_en_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status is a registered view of the next state.
  always_comb begin
    busy_d = (state_d == RESET) || (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == ERR_ZERO);
  end

  // All controller state and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      cyc_q     <= CNT_ZERO;
      tog_q     <= CNT_ZERO;
      ff_q      <= FAIL_NONE_W;
      err_q     <= ERR_ZERO;
      dut_rst_q <= 1'b1;
      dut_en_q  <= 1'b0;
      dut_d_q   <= DATA_ZERO;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      tog_q     <= tog_d;
      ff_q      <= ff_d;
      err_q     <= err_d;
      dut_rst_q <= dut_rst_d;
      dut_en_q  <= dut_en_d;
      dut_d_q   <= dut_d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign bus.dut_rst          = dut_rst_q;
  assign bus.dut_en           = dut_en_q;
  assign bus.dut_d            = dut_d_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_cycle = ff_q;

endmodule
